// File: rtl/sad_stage_reg.sv
// sad_stage_reg: MEM -> SAD1 pipeline register for the SAD datapath.
// Carries the scalar writeback bundle and captures vector lanes into a
// window bank (SADM=3) or a frame bank (SADM=1/2), with bank-valid flags
// and a saturating frame-capture counter.
// Optional feature macro: SAD_STAGE_FLUSH_EN adds the Flush port (bubble
// insertion, priority over Stall). Without it Flush is tied low internally.
module sad_stage_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned LANE_W    = 32,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          Stall,
`ifdef SAD_STAGE_FLUSH_EN
  input  logic                          Flush,
`endif
  input  logic                          ValidM,
  input  logic [CTRL_W-1:0]             CtrlM,
  input  logic [DATA_W-1:0]             ALUResultM,
  input  logic [DATA_W-1:0]             MemReadDataM,
  input  logic [DATA_W-1:0]             PCPlus4M,
  input  logic [DATA_W-1:0]             InstructionM,
  input  logic [REG_AW-1:0]             WriteRegM,
  input  logic [1:0]                    SADM,
  input  logic [NUM_LANES*LANE_W-1:0]   VecM,
  output logic                          ValidSAD1,
  output logic [CTRL_W-1:0]             CtrlSAD1,
  output logic [DATA_W-1:0]             ALUResultSAD1,
  output logic [DATA_W-1:0]             MemReadDataSAD1,
  output logic [DATA_W-1:0]             PCPlus4SAD1,
  output logic [DATA_W-1:0]             InstructionSAD1,
  output logic [REG_AW-1:0]             WriteRegSAD1,
  output logic [1:0]                    SADSAD1,
  output logic [NUM_LANES*LANE_W-1:0]   WinSAD1,
  output logic [NUM_LANES*LANE_W-1:0]   FrmSAD1,
  output logic                          WinValidSAD1,
  output logic                          FrmValidSAD1,
  output logic [CNT_W-1:0]              FrmCountSAD1,
  output logic                          BankReadySAD1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic flush;
  logic advance;
  logic capture;

`ifdef SAD_STAGE_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  // Flush forces an advance even while stalled; captures need a real valid op
  assign advance = ~Stall | flush;
  assign capture = advance & ~flush & ValidM;

  // Scalar writeback bundle; flush zeroes only the fields that carry intent
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ValidSAD1       <= 1'b0;
      CtrlSAD1        <= '0;
      ALUResultSAD1   <= '0;
      MemReadDataSAD1 <= '0;
      PCPlus4SAD1     <= '0;
      InstructionSAD1 <= '0;
      WriteRegSAD1    <= '0;
      SADSAD1         <= 2'b00;
    end else if (advance) begin
      ValidSAD1       <= ValidM & ~flush;
      CtrlSAD1        <= flush ? '0 : CtrlM;
      SADSAD1         <= flush ? 2'b00 : SADM;
      ALUResultSAD1   <= ALUResultM;
      MemReadDataSAD1 <= MemReadDataM;
      PCPlus4SAD1     <= PCPlus4M;
      InstructionSAD1 <= InstructionM;
      WriteRegSAD1    <= WriteRegM;
    end
  end

  // Vector banks, valid flags and frame counter; a new window drops the old frame
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      WinSAD1      <= '0;
      FrmSAD1      <= '0;
      WinValidSAD1 <= 1'b0;
      FrmValidSAD1 <= 1'b0;
      FrmCountSAD1 <= '0;
    end else if (capture) begin
      case (SADM)
        2'd3: begin
          WinSAD1      <= VecM;
          WinValidSAD1 <= 1'b1;
          FrmValidSAD1 <= 1'b0;
          FrmCountSAD1 <= '0;
        end
        2'd1, 2'd2: begin
          FrmSAD1      <= VecM;
          FrmValidSAD1 <= 1'b1;
          if (FrmCountSAD1 != CNT_MAX) begin
            FrmCountSAD1 <= FrmCountSAD1 + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign BankReadySAD1 = WinValidSAD1 & FrmValidSAD1;

endmodule

// File: tb/tb_sad_stage_reg.sv
// Self-checking bench for sad_stage_reg: directed scenarios with literal
// expectations plus randomized traffic checked against a lane-array model.
// Flush scenarios are included when SAD_STAGE_FLUSH_EN is defined.
module tb_sad_stage_reg;

  localparam int DATA_W    = 32;
  localparam int REG_AW    = 5;
  localparam int CTRL_W    = 8;
  localparam int NUM_LANES = 16;
  localparam int LANE_W    = 32;
  localparam int CNT_W     = 4;
  localparam int VEC_W     = NUM_LANES * LANE_W;
  localparam int CNT_SAT   = (1 << CNT_W) - 1;

  logic                 Clk, Reset_n, Stall, ValidM;
`ifdef SAD_STAGE_FLUSH_EN
  logic                 Flush;
`endif
  logic [CTRL_W-1:0]    CtrlM;
  logic [DATA_W-1:0]    ALUResultM, MemReadDataM, PCPlus4M, InstructionM;
  logic [REG_AW-1:0]    WriteRegM;
  logic [1:0]           SADM;
  logic [VEC_W-1:0]     VecM;
  logic                 ValidSAD1;
  logic [CTRL_W-1:0]    CtrlSAD1;
  logic [DATA_W-1:0]    ALUResultSAD1, MemReadDataSAD1, PCPlus4SAD1, InstructionSAD1;
  logic [REG_AW-1:0]    WriteRegSAD1;
  logic [1:0]           SADSAD1;
  logic [VEC_W-1:0]     WinSAD1, FrmSAD1;
  logic                 WinValidSAD1, FrmValidSAD1, BankReadySAD1;
  logic [CNT_W-1:0]     FrmCountSAD1;

  sad_stage_reg #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .CTRL_W(CTRL_W),
    .NUM_LANES(NUM_LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall),
`ifdef SAD_STAGE_FLUSH_EN
    .Flush(Flush),
`endif
    .ValidM(ValidM), .CtrlM(CtrlM), .ALUResultM(ALUResultM),
    .MemReadDataM(MemReadDataM), .PCPlus4M(PCPlus4M), .InstructionM(InstructionM),
    .WriteRegM(WriteRegM), .SADM(SADM), .VecM(VecM),
    .ValidSAD1(ValidSAD1), .CtrlSAD1(CtrlSAD1), .ALUResultSAD1(ALUResultSAD1),
    .MemReadDataSAD1(MemReadDataSAD1), .PCPlus4SAD1(PCPlus4SAD1),
    .InstructionSAD1(InstructionSAD1), .WriteRegSAD1(WriteRegSAD1),
    .SADSAD1(SADSAD1), .WinSAD1(WinSAD1), .FrmSAD1(FrmSAD1),
    .WinValidSAD1(WinValidSAD1), .FrmValidSAD1(FrmValidSAD1),
    .FrmCountSAD1(FrmCountSAD1), .BankReadySAD1(BankReadySAD1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: banks as lane arrays, counter as a saturating integer
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_alu, m_mem, m_pc, m_ins;
  logic [REG_AW-1:0] m_wr;
  logic [1:0]        m_sad;
  logic [LANE_W-1:0] m_win [NUM_LANES];
  logic [LANE_W-1:0] m_frm [NUM_LANES];
  bit                m_winv, m_frmv;
  int                m_cnt;

  function automatic logic [VEC_W-1:0] pack(input logic [LANE_W-1:0] a [NUM_LANES]);
    logic [VEC_W-1:0] v;
    for (int i = 0; i < NUM_LANES; i++) v[i*LANE_W +: LANE_W] = a[i];
    return v;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    bit fl;
    if (!Reset_n) begin
      m_valid <= 0; m_ctrl <= '0; m_alu <= '0; m_mem <= '0; m_pc <= '0;
      m_ins <= '0; m_wr <= '0; m_sad <= '0; m_winv <= 0; m_frmv <= 0; m_cnt <= 0;
      for (int i = 0; i < NUM_LANES; i++) begin m_win[i] <= '0; m_frm[i] <= '0; end
    end else begin
`ifdef SAD_STAGE_FLUSH_EN
      fl = Flush;
`else
      fl = 1'b0;
`endif
      if (fl || !Stall) begin
        m_valid <= fl ? 1'b0 : ValidM;
        m_ctrl  <= fl ? '0 : CtrlM;
        m_sad   <= fl ? 2'b00 : SADM;
        m_alu <= ALUResultM; m_mem <= MemReadDataM; m_pc <= PCPlus4M;
        m_ins <= InstructionM; m_wr <= WriteRegM;
        if (!fl && ValidM) begin
          if (SADM == 2'd3) begin
            for (int i = 0; i < NUM_LANES; i++) m_win[i] <= VecM[i*LANE_W +: LANE_W];
            m_winv <= 1; m_frmv <= 0; m_cnt <= 0;
          end else if (SADM != 2'd0) begin
            for (int i = 0; i < NUM_LANES; i++) m_frm[i] <= VecM[i*LANE_W +: LANE_W];
            m_frmv <= 1;
            m_cnt  <= (m_cnt >= CNT_SAT) ? CNT_SAT : m_cnt + 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("valid",  VEC_W'(ValidSAD1),       VEC_W'(m_valid));
      chk("ctrl",   VEC_W'(CtrlSAD1),        VEC_W'(m_ctrl));
      chk("alu",    VEC_W'(ALUResultSAD1),   VEC_W'(m_alu));
      chk("mem",    VEC_W'(MemReadDataSAD1), VEC_W'(m_mem));
      chk("pc4",    VEC_W'(PCPlus4SAD1),     VEC_W'(m_pc));
      chk("instr",  VEC_W'(InstructionSAD1), VEC_W'(m_ins));
      chk("wreg",   VEC_W'(WriteRegSAD1),    VEC_W'(m_wr));
      chk("sad",    VEC_W'(SADSAD1),         VEC_W'(m_sad));
      chk("win",    WinSAD1,                 pack(m_win));
      chk("frm",    FrmSAD1,                 pack(m_frm));
      chk("winv",   VEC_W'(WinValidSAD1),    VEC_W'(m_winv));
      chk("frmv",   VEC_W'(FrmValidSAD1),    VEC_W'(m_frmv));
      chk("cnt",    VEC_W'(FrmCountSAD1),    VEC_W'(m_cnt));
      chk("ready",  VEC_W'(BankReadySAD1),   VEC_W'(m_winv && m_frmv));
    end
  end

  // Drive one M-stage beat; vbase<0 means random lanes
  task automatic drive(input bit v, input logic [1:0] s, input bit st, input int vbase);
    ValidM = v; SADM = s; Stall = st;
    CtrlM = CTRL_W'($urandom); ALUResultM = $urandom; MemReadDataM = $urandom;
    PCPlus4M = $urandom; InstructionM = $urandom; WriteRegM = REG_AW'($urandom);
    for (int i = 0; i < NUM_LANES; i++)
      VecM[i*LANE_W +: LANE_W] = (vbase < 0) ? LANE_W'($urandom) : LANE_W'(vbase + i);
  endtask

  // Drive then advance past the next rising edge
  task automatic cyc(input bit v, input logic [1:0] s, input bit st, input int vbase);
    drive(v, s, st, vbase);
    @(posedge Clk); #1;
  endtask

  function automatic logic [LANE_W-1:0] lane(input logic [VEC_W-1:0] vec, input int i);
    return vec[i*LANE_W +: LANE_W];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_scalars"}, VEC_W'({ValidSAD1, CtrlSAD1, ALUResultSAD1, MemReadDataSAD1,
        PCPlus4SAD1, InstructionSAD1, WriteRegSAD1, SADSAD1}), '0);
    chk({tag, "_win"}, WinSAD1, '0);
    chk({tag, "_frm"}, FrmSAD1, '0);
    chk({tag, "_flags"}, VEC_W'({WinValidSAD1, FrmValidSAD1, BankReadySAD1, FrmCountSAD1}), '0);
  endtask

  logic [DATA_W-1:0] saved_alu;
  logic [CTRL_W-1:0] saved_ctrl;

  initial begin
`ifdef SAD_STAGE_FLUSH_EN
    Flush = 1'b0;
`endif
    Reset_n = 1'b1;
    drive(1'b1, 2'd3, 1'b0, 7);
    #1 Reset_n = 1'b0;
    #2 chk_all_zero("reset");
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    chk_en = 1'b1;

    // Window then frame
    cyc(1'b1, 2'd3, 1'b0, 0);
    chk("wf_winv", VEC_W'(WinValidSAD1), 1);
    chk("wf_frmv", VEC_W'(FrmValidSAD1), 0);
    cyc(1'b1, 2'd1, 1'b0, 'h100);
    chk("wf_win_lane5", VEC_W'(lane(WinSAD1, 5)), 5);
    chk("wf_frm_lane5", VEC_W'(lane(FrmSAD1, 5)), 'h105);
    chk("wf_ready", VEC_W'(BankReadySAD1), 1);
    chk("wf_cnt", VEC_W'(FrmCountSAD1), 1);

    // Counter saturation, then a window clears it
    for (int k = 0; k < 20; k++) cyc(1'b1, 2'd2, 1'b0, -1);
    chk("sat_cnt", VEC_W'(FrmCountSAD1), 15);
    cyc(1'b1, 2'd3, 1'b0, -1);
    chk("sat_clr_cnt", VEC_W'(FrmCountSAD1), 0);
    chk("sat_clr_frmv", VEC_W'(FrmValidSAD1), 0);

    // Stall holds everything, release loads the pending beat
    drive(1'b1, 2'd3, 1'b0, 'h200);
    saved_alu = ALUResultM; saved_ctrl = CtrlM;
    @(posedge Clk); #1;
    for (int k = 0; k < 3; k++) cyc(1'b1, 2'd3, 1'b1, 'h300);
    chk("stall_win_lane3", VEC_W'(lane(WinSAD1, 3)), 'h203);
    chk("stall_alu", VEC_W'(ALUResultSAD1), VEC_W'(saved_alu));
    chk("stall_ctrl", VEC_W'(CtrlSAD1), VEC_W'(saved_ctrl));
    cyc(1'b1, 2'd3, 1'b0, 'h300);
    chk("release_win_lane3", VEC_W'(lane(WinSAD1, 3)), 'h303);

    // Invalid op must not capture
    cyc(1'b1, 2'd1, 1'b0, 'h400);
    cyc(1'b0, 2'd1, 1'b0, 'h500);
    chk("inv_valid", VEC_W'(ValidSAD1), 0);
    chk("inv_frmv", VEC_W'(FrmValidSAD1), 1);
    chk("inv_cnt", VEC_W'(FrmCountSAD1), 1);
    chk("inv_frm_lane0", VEC_W'(lane(FrmSAD1, 0)), 'h400);

`ifdef SAD_STAGE_FLUSH_EN
    // Flush beats stall and blocks capture
    Flush = 1'b1;
    cyc(1'b1, 2'd3, 1'b1, 'h600);
    Flush = 1'b0;
    chk("fl_valid", VEC_W'(ValidSAD1), 0);
    chk("fl_ctrl", VEC_W'(CtrlSAD1), 0);
    chk("fl_sad", VEC_W'(SADSAD1), 0);
    chk("fl_win_lane3", VEC_W'(lane(WinSAD1, 3)), 'h303);
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
`ifdef SAD_STAGE_FLUSH_EN
      Flush = ($urandom_range(0, 9) == 0);
`endif
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 4) == 0, -1);
    end
`ifdef SAD_STAGE_FLUSH_EN
    Flush = 1'b0;
`endif

    // Asynchronous reset between edges, then immediate normal load
    drive(1'b1, 2'd1, 1'b0, -1);
    #1 Reset_n = 1'b0;
    #1 chk_all_zero("midreset");
    #1 Reset_n = 1'b1;
    cyc(1'b1, 2'd3, 1'b0, 'h700);
    chk("post_reset_valid", VEC_W'(ValidSAD1), 1);
    chk("post_reset_win_lane2", VEC_W'(lane(WinSAD1, 2)), 'h702);
    for (int k = 0; k < 5; k++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b0, -1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
